// File: rtl/core_sequencer_if.sv
// core_sequencer_if: instruction-fetch and data-access req/ack bus between sequencer and memories.
interface core_sequencer_if;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_ack;
    logic [31:0] i_imem_rdata;
    logic        o_dmem_req;
    logic        i_dmem_ack;
    modport master (
        output o_imem_req, o_imem_addr, o_dmem_req,
        input  i_imem_ack, i_imem_rdata, i_dmem_ack
    );
    modport slave (
        input  o_imem_req, o_imem_addr, o_dmem_req,
        output i_imem_ack, i_imem_rdata, i_dmem_ack
    );
endinterface

// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle RV32I control FSM (fetch/decode/execute/memory/writeback, sticky trap).
// Defining SEQ_PERF_COUNTERS_EN adds the o_cycle/o_instret performance counters.
module core_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'h80000000,
    parameter int          BUS_TIMEOUT = 255
) (
    input  logic             i_clk,
    input  logic             i_rst,
    core_sequencer_if.master io_bus,
    output logic [31:0]      o_opcode,
    output logic [31:0]      o_pc,
    input  logic             i_illegal_instruction,
    input  logic             i_en_jump,
    input  logic [31:0]      i_jump_addr,
    input  logic             i_mem_op,
    output logic             o_rf_we,
    output logic             o_trap,
    output logic [1:0]       o_trap_cause
`ifdef SEQ_PERF_COUNTERS_EN
    ,
    output logic [63:0]      o_cycle,
    output logic [63:0]      o_instret
`endif
);
    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_TRAP} state_t;
    state_t      r_state;
    logic        r_imem_req, r_dmem_req, r_rf_we, r_trap;
    logic [1:0]  r_trap_cause;
    logic [31:0] r_pc, r_opcode;
    logic [15:0] r_tmo;
    logic        w_tmo_hit, w_misaligned;
    logic [31:0] w_pc_next;
    // The cycle that would make the wait count reach BUS_TIMEOUT traps instead of counting.
    assign w_tmo_hit    = r_tmo == 16'(BUS_TIMEOUT - 1);
    assign w_misaligned = i_en_jump && (i_jump_addr[1:0] != 2'b00);
    assign w_pc_next    = i_en_jump ? i_jump_addr : r_pc + 32'd4;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_FETCH;
            r_pc         <= RESET_PC;
            r_opcode     <= 32'h00000013;
            r_imem_req   <= 1'b0;
            r_dmem_req   <= 1'b0;
            r_rf_we      <= 1'b0;
            r_trap       <= 1'b0;
            r_trap_cause <= 2'd0;
            r_tmo        <= 16'd0;
        end else begin
            r_rf_we <= 1'b0;
            case (r_state)
                S_FETCH: begin
                    if (r_imem_req && io_bus.i_imem_ack) begin
                        r_opcode   <= io_bus.i_imem_rdata;
                        r_imem_req <= 1'b0;
                        r_state    <= S_DECODE;
                    end else if (r_imem_req && w_tmo_hit) begin
                        r_imem_req   <= 1'b0;
                        r_trap       <= 1'b1;
                        r_trap_cause <= 2'd2;
                        r_state      <= S_TRAP;
                    end else if (r_imem_req) begin
                        r_tmo <= r_tmo + 16'd1;
                    end else begin
                        r_imem_req <= 1'b1;
                    end
                end
                S_DECODE: begin
                    if (i_illegal_instruction) begin
                        r_trap       <= 1'b1;
                        r_trap_cause <= 2'd0;
                        r_state      <= S_TRAP;
                    end else begin
                        r_state <= S_EXECUTE;
                    end
                end
                S_EXECUTE: begin
                    if (i_mem_op) begin
                        r_dmem_req <= 1'b1;
                        r_tmo      <= 16'd0;
                        r_state    <= S_MEMORY;
                    end else begin
                        r_rf_we <= 1'b1;
                        r_state <= S_WRITEBACK;
                    end
                end
                S_MEMORY: begin
                    if (io_bus.i_dmem_ack) begin
                        r_dmem_req <= 1'b0;
                        r_rf_we    <= 1'b1;
                        r_state    <= S_WRITEBACK;
                    end else if (w_tmo_hit) begin
                        r_dmem_req   <= 1'b0;
                        r_trap       <= 1'b1;
                        r_trap_cause <= 2'd2;
                        r_state      <= S_TRAP;
                    end else begin
                        r_tmo <= r_tmo + 16'd1;
                    end
                end
                S_WRITEBACK: begin
                    if (w_misaligned) begin
                        r_trap       <= 1'b1;
                        r_trap_cause <= 2'd1;
                        r_state      <= S_TRAP;
                    end else begin
                        r_pc       <= w_pc_next;
                        r_imem_req <= 1'b1;
                        r_tmo      <= 16'd0;
                        r_state    <= S_FETCH;
                    end
                end
                S_TRAP: r_state <= S_TRAP;
                default: r_state <= S_FETCH;
            endcase
        end
    end
    assign io_bus.o_imem_req  = r_imem_req;
    assign io_bus.o_imem_addr = r_pc;
    assign io_bus.o_dmem_req  = r_dmem_req;
    assign o_opcode           = r_opcode;
    assign o_pc               = r_pc;
    assign o_rf_we            = r_rf_we;
    assign o_trap             = r_trap;
    assign o_trap_cause       = r_trap_cause;
`ifdef SEQ_PERF_COUNTERS_EN
    logic [63:0] r_cycle, r_instret;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cycle   <= 64'd0;
            r_instret <= 64'd0;
        end else begin
            if (r_state != S_TRAP) r_cycle <= r_cycle + 64'd1;
            if (r_state == S_WRITEBACK && !w_misaligned) r_instret <= r_instret + 64'd1;
        end
    end
    assign o_cycle   = r_cycle;
    assign o_instret = r_instret;
`endif
endmodule

// File: tb/tb_core_sequencer.sv
// tb_core_sequencer: scoreboard bench; stimulus queues expected bus/writeback/trap events and
// state snapshots, an independent monitor pops and compares as the DUT produces them.
module tb_core_sequencer;
    localparam logic [31:0] RST_PC = 32'h80000000;
    localparam logic [31:0] NOP    = 32'h00000013;
    localparam int K_FETCH = 0, K_DMEM = 1, K_WE = 2, K_TRAP = 3, K_SNAP = 4;
    typedef struct {
        int          k;
        logic [95:0] v;
        int          t;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    core_sequencer_if bus();
    logic [31:0] opcode, pc;
    logic [31:0] jaddr = 32'd0;
    logic illegal = 1'b0, en_jump = 1'b0, mem_op = 1'b0;
    logic rf_we, trap;
    logic [1:0] cause;
`ifdef SEQ_PERF_COUNTERS_EN
    logic [63:0] cycle_cnt, instret_cnt;
`endif

    core_sequencer #(.RESET_PC(RST_PC), .BUS_TIMEOUT(4)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .io_bus(bus),
        .o_opcode(opcode),
        .o_pc(pc),
        .i_illegal_instruction(illegal),
        .i_en_jump(en_jump),
        .i_jump_addr(jaddr),
        .i_mem_op(mem_op),
        .o_rf_we(rf_we),
        .o_trap(trap),
        .o_trap_cause(cause)
`ifdef SEQ_PERF_COUNTERS_EN
        ,
        .o_cycle(cycle_cnt),
        .o_instret(instret_cnt)
`endif
    );

    ev_t q_ev[$];
    ev_t q_snap[$];
    int cyc = 0, mark = 0, n_chk = 0, n_pass = 0, probe_req = 0;
    int idly = 0, ddly = 0, iw = 0, dw = 0;
    logic [31:0] instr = NOP;
    int mon_pdone = 0, mon_dcnt = 0;
    logic mon_trap_q = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [95:0] snapv(input logic rq, input logic dq, input logic we,
                                          input logic tr, input logic [1:0] c,
                                          input logic [31:0] p, input logic [31:0] o);
        return {26'b0, rq, dq, we, tr, c, p, o};
    endfunction

    function automatic string kname(input int k);
        return k == K_FETCH ? "fetch" : k == K_DMEM ? "dmem" : k == K_WE ? "rf_we" :
               k == K_TRAP ? "trap" : "snapshot";
    endfunction

    task automatic push(input int k, input logic [95:0] v, input int t);
        ev_t e;
        e.k = k;
        e.v = v;
        e.t = t;
        if (k == K_SNAP) q_snap.push_back(e);
        else q_ev.push_back(e);
    endtask

    task automatic got(input int k, input logic [95:0] v, input int t);
        ev_t e;
        n_chk++;
        if ((k == K_SNAP && q_snap.size() == 0) || (k != K_SNAP && q_ev.size() == 0)) begin
            $display("FAIL unexpected %s: got val=%h t=%0d, required no event", kname(k), v, t);
            return;
        end
        if (k == K_SNAP) e = q_snap.pop_front();
        else e = q_ev.pop_front();
        if (e.k == k && e.v === v && (e.t < 0 || e.t == t)) n_pass++;
        else $display("FAIL %s: got %s val=%h t=%0d, required %s val=%h t=%0d",
                      kname(e.k), kname(k), v, t, kname(e.k), e.v, e.t);
    endtask

    // Memory responders: ack after a programmed number of waiting req cycles (-1 = never).
    initial begin
        bus.i_imem_ack   = 1'b0;
        bus.i_imem_rdata = 32'hDEADBEEF;
        bus.i_dmem_ack   = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.o_imem_req === 1'b1 && iw == idly) begin
                bus.i_imem_ack   = 1'b1;
                bus.i_imem_rdata = instr;
                iw = 0;
            end else begin
                bus.i_imem_ack   = 1'b0;
                bus.i_imem_rdata = 32'hDEADBEEF;
                iw = (bus.o_imem_req === 1'b1) ? iw + 1 : 0;
            end
            if (bus.o_dmem_req === 1'b1 && dw == ddly) begin
                bus.i_dmem_ack = 1'b1;
                dw = 0;
            end else begin
                bus.i_dmem_ack = 1'b0;
                dw = (bus.o_dmem_req === 1'b1) ? dw + 1 : 0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (probe_req != mon_pdone) begin
                mon_pdone = probe_req;
                got(K_SNAP, snapv(bus.o_imem_req, bus.o_dmem_req, rf_we, trap, cause, pc, opcode), cyc - mark);
            end
            if (!rst) begin
                if (bus.o_imem_req && bus.i_imem_ack) got(K_FETCH, {64'b0, bus.o_imem_addr}, cyc - mark);
                mon_dcnt = bus.o_dmem_req ? mon_dcnt + 1 : 0;
                if (bus.o_dmem_req && bus.i_dmem_ack) got(K_DMEM, 96'(mon_dcnt), cyc - mark);
                if (rf_we) got(K_WE, {64'b0, pc}, cyc - mark);
                if (trap && !mon_trap_q) got(K_TRAP, {62'b0, cause, pc}, cyc - mark);
            end
            mon_trap_q = trap;
        end
    end

    task automatic wait_to(input int t);
        int guard = 0;
        while (cyc - mark < t && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
    endtask

    task automatic probe(input logic [95:0] v);
        push(K_SNAP, v, -1);
        probe_req++;
    endtask

    task automatic start_phase(input int id, input int dd, input logic [31:0] ins, input logic mo,
                               input logic il, input logic ej, input logic [31:0] ja);
        @(negedge clk);
        rst = 1'b1;
        idly = id; ddly = dd; instr = ins;
        mem_op = mo; illegal = il; en_jump = ej; jaddr = ja;
        @(negedge clk);
        probe(snapv(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, RST_PC, NOP));
        @(negedge clk);
        rst = 1'b0;
        mark = cyc;
    endtask

    task automatic end_phase(input int t);
        wait_to(t);
        #2;
        n_chk++;
        if (q_ev.size() == 0 && q_snap.size() == 0) n_pass++;
        else begin
            $display("FAIL pending: %0d events and %0d snapshots never seen, required 0", q_ev.size(), q_snap.size());
            q_ev.delete();
            q_snap.delete();
        end
    endtask

    initial begin
        // Back-to-back nops: 4-cycle instruction spacing, one rf_we per instruction.
        start_phase(0, 0, NOP, 1'b0, 1'b0, 1'b0, 32'd0);
        push(K_FETCH, 96'(32'h80000000), 1);
        push(K_WE,    96'(32'h80000000), 4);
        push(K_FETCH, 96'(32'h80000004), 5);
        push(K_WE,    96'(32'h80000004), 8);
        push(K_FETCH, 96'(32'h80000008), 9);
        end_phase(10);
        // Fetch ack on the 4th req cycle (also the timeout boundary: ack wins).
        start_phase(3, 0, 32'h00A00093, 1'b0, 1'b0, 1'b0, 32'd0);
        push(K_FETCH, 96'(32'h80000000), 4);
        push(K_WE,    96'(32'h80000000), 7);
        push(K_FETCH, 96'(32'h80000004), 11);
        wait_to(3);
        probe(snapv(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, RST_PC, NOP));
        wait_to(5);
        probe(snapv(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, RST_PC, 32'h00A00093));
        end_phase(12);
        // Memory op, dmem ack after 2 waiting cycles.
        start_phase(0, 2, 32'h00002083, 1'b1, 1'b0, 1'b0, 32'd0);
        push(K_FETCH, 96'(32'h80000000), 1);
        push(K_DMEM,  96'(3), 6);
        push(K_WE,    96'(32'h80000000), 7);
        push(K_FETCH, 96'(32'h80000004), 8);
        wait_to(5);
        probe(snapv(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, RST_PC, 32'h00002083));
        end_phase(9);
        // Aligned jump.
        start_phase(0, 0, NOP, 1'b0, 1'b0, 1'b1, 32'h80000100);
        push(K_FETCH, 96'(32'h80000000), 1);
        push(K_WE,    96'(32'h80000000), 4);
        push(K_FETCH, 96'(32'h80000100), 5);
        push(K_WE,    96'(32'h80000100), 8);
        push(K_FETCH, 96'(32'h80000100), 9);
        end_phase(10);
        // Misaligned jump: rf_we still pulses, then trap cause 1 with PC held.
        start_phase(0, 0, NOP, 1'b0, 1'b0, 1'b1, 32'h80000102);
        push(K_FETCH, 96'(32'h80000000), 1);
        push(K_WE,    96'(32'h80000000), 4);
        push(K_TRAP,  {62'b0, 2'd1, 32'h80000000}, 5);
        wait_to(8);
        probe(snapv(1'b0, 1'b0, 1'b0, 1'b1, 2'd1, RST_PC, NOP));
        end_phase(20);
        // PC wraps from FFFFFFFC to 0.
        start_phase(0, 0, NOP, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFC);
        push(K_FETCH, 96'(32'h80000000), 1);
        push(K_WE,    96'(32'h80000000), 4);
        push(K_FETCH, 96'(32'hFFFFFFFC), 5);
        push(K_WE,    96'(32'hFFFFFFFC), 8);
        push(K_FETCH, 96'(32'h00000000), 9);
        wait_to(6);
        en_jump = 1'b0;
        end_phase(10);
        // Illegal instruction: trap cause 0 from DECODE, no rf_we.
        start_phase(0, 0, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 32'd0);
        push(K_FETCH, 96'(32'h80000000), 1);
        push(K_TRAP,  {62'b0, 2'd0, 32'h80000000}, 3);
        wait_to(4);
        probe(snapv(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, RST_PC, 32'hFFFFFFFF));
        end_phase(15);
        // Fetch never acked: trap cause 2 after 4 req cycles.
        start_phase(-1, 0, NOP, 1'b0, 1'b0, 1'b0, 32'd0);
        push(K_TRAP, {62'b0, 2'd2, 32'h80000000}, 5);
        wait_to(4);
        probe(snapv(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, RST_PC, NOP));
        wait_to(5);
        probe(snapv(1'b0, 1'b0, 1'b0, 1'b1, 2'd2, RST_PC, NOP));
        end_phase(12);
        // Reset asserted in MEMORY while dmem req is high.
        start_phase(0, -1, 32'h00002083, 1'b1, 1'b0, 1'b0, 32'd0);
        push(K_FETCH, 96'(32'h80000000), 1);
        wait_to(5);
        probe(snapv(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, RST_PC, 32'h00002083));
        rst = 1'b1;
        wait_to(6);
        probe(snapv(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, RST_PC, NOP));
        end_phase(8);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end
endmodule
